// File: rtl/tile_judge_seq.sv
// tile_judge_seq: beat-driven note sequencer with a multi-lane PS/2 key judge.
// Fetches one note per beat tick from a registered pattern memory and scores presses in a timed window.
module tile_judge_seq #(
    parameter int                 LANES      = 4,
    parameter logic [LANES*8-1:0] LANE_CODES = {8'h2b, 8'h23, 8'h1b, 8'h1c},
    parameter int                 SEQ_LEN    = 64,
    parameter int                 WINDOW_CYC = 12500000,
    parameter int                 SCORE_W    = 16,
    localparam int                LW         = LANES > 1 ? $clog2(LANES) : 1,
    localparam int                AW         = $clog2(SEQ_LEN),
    localparam int                CW         = $clog2(WINDOW_CYC + 1)
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               t,
    input  logic [7:0]         scancode,
    input  logic               scan_valid,
    output logic [AW-1:0]      seq_addr,
    input  logic [LW:0]        seq_note,
    output logic [LW-1:0]      expected_lane,
    output logic               expected_valid,
    output logic               hit,
    output logic               miss,
    output logic [1:0]         click_state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] combo,
    output logic [SCORE_W-1:0] max_combo,
    output logic               done
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_ARMED  = 3'd4;
    localparam logic [2:0] S_JUDGED = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [1:0] C_WAIT   = 2'd0;
    localparam logic [1:0] C_SCORE  = 2'd1;
    localparam logic [1:0] C_MISS   = 2'd2;
    localparam logic [SCORE_W-1:0] SMAX = '1;

    logic [2:0]         state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]      lane_q, lane_d;
    logic               valid_q, valid_d;
    logic               brk_q, brk_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic [1:0]         click_q, click_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] combo_q, combo_d;
    logic [SCORE_W-1:0] maxc_q, maxc_d;
    logic               done_q, done_d;
    logic               press_match, press, good, last, expire, closing;
    logic [LW-1:0]      press_lane;
    logic [SCORE_W-1:0] combo_inc;

    // Descending scan so the lowest matching lane is the one left standing.
    always_comb begin
        press_match = 1'b0;
        press_lane  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (scancode == LANE_CODES[8*i +: 8]) begin
                press_match = 1'b1;
                press_lane  = LW'(i);
            end
        end
    end

    assign press     = scan_valid && !brk_q && scancode != 8'hF0 && scancode != 8'hE0 && press_match;
    assign good      = press && valid_q && press_lane == lane_q;
    assign last      = addr_q == AW'(SEQ_LEN - 1);
    assign expire    = cnt_q == CW'(1);
    assign closing   = press || expire || t;
    assign combo_inc = combo_q + SCORE_W'(combo_q != SMAX);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        valid_d = valid_q;
        brk_d   = brk_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        click_d = click_q;
        score_d = score_q;
        combo_d = combo_q;
        maxc_d  = maxc_q;
        done_d  = done_q;
        if (scan_valid)
            brk_d = scancode == 8'hF0 ? 1'b1 : scancode == 8'hE0 ? brk_q : 1'b0;
        if (start) begin
            state_d = S_WAIT;
            addr_d  = '0;
            valid_d = 1'b0;
            score_d = '0;
            combo_d = '0;
            maxc_d  = '0;
            done_d  = 1'b0;
        end else if ((state_q == S_WAIT || state_q == S_JUDGED) && t) begin
            // The first tick after start fetches beat 0 without advancing.
            state_d = S_FETCH;
            addr_d  = state_q == S_JUDGED ? addr_q + AW'(1) : addr_q;
        end else if (state_q == S_FETCH) begin
            state_d = S_LOAD;
        end else if (state_q == S_LOAD) begin
            state_d = S_ARMED;
            lane_d  = seq_note[LW-1:0];
            valid_d = seq_note[LW];
            cnt_d   = CW'(WINDOW_CYC);
            click_d = C_WAIT;
        end else if (state_q == S_ARMED) begin
            cnt_d  = cnt_q - CW'(1);
            hit_d  = good;
            miss_d = !good && (press || (valid_q && (expire || t)));
            if (good) begin
                score_d = score_q + SCORE_W'(score_q != SMAX);
                combo_d = combo_inc;
                maxc_d  = combo_inc > maxc_q ? combo_inc : maxc_q;
                click_d = C_SCORE;
            end
            if (miss_d) begin
                combo_d = '0;
                click_d = C_MISS;
            end
            if (closing) begin
                state_d = last ? S_DONE : t ? S_FETCH : S_JUDGED;
                addr_d  = (t && !last) ? addr_q + AW'(1) : addr_q;
                done_d  = last;
                valid_d = valid_q && !last;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
            brk_q   <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            click_q <= C_WAIT;
            score_q <= '0;
            combo_q <= '0;
            maxc_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
            brk_q   <= brk_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            click_q <= click_d;
            score_q <= score_d;
            combo_q <= combo_d;
            maxc_q  <= maxc_d;
            done_q  <= done_d;
        end
    end

    assign seq_addr       = addr_q;
    assign expected_lane  = lane_q;
    assign expected_valid = valid_q;
    assign hit            = hit_q;
    assign miss           = miss_q;
    assign click_state    = click_q;
    assign score          = score_q;
    assign combo          = combo_q;
    assign max_combo      = maxc_q;
    assign done           = done_q;
endmodule

// File: tb/tb_tile_judge_seq.sv
// tb_tile_judge_seq: directed and random stimulus for tile_judge_seq, checked every cycle
// against an event-timestamp reference model of the game rules.
module tb_tile_judge_seq;
    localparam int LANES   = 4;
    localparam int SEQ_LEN = 16;
    localparam int WIN     = 16;
    localparam int SW      = 3;
    localparam int SMAX    = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       t = 1'b0;
    logic       scan_valid = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic [3:0] seq_addr;
    logic [2:0] seq_note = 3'b000;
    logic [1:0] expected_lane;
    logic       expected_valid, hit, miss, done;
    logic [1:0] click_state;
    logic [SW-1:0] score, combo, max_combo;

    logic [2:0] pat [SEQ_LEN];
    logic [7:0] keys [LANES] = '{8'h1c, 8'h1b, 8'h23, 8'h2b};
    int compared = 0;
    int mismatched = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;
    always @(posedge clk) seq_note <= pat[seq_addr];

    tile_judge_seq #(
        .LANES(LANES), .LANE_CODES({8'h2b, 8'h23, 8'h1b, 8'h1c}),
        .SEQ_LEN(SEQ_LEN), .WINDOW_CYC(WIN), .SCORE_W(SW)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .t(t),
        .scancode(scancode), .scan_valid(scan_valid), .seq_addr(seq_addr),
        .seq_note(seq_note), .expected_lane(expected_lane), .expected_valid(expected_valid),
        .hit(hit), .miss(miss), .click_state(click_state), .score(score),
        .combo(combo), .max_combo(max_combo), .done(done)
    );

    // Reference model: beats are tracked by edge timestamps (arm edge, deadline edge).
    int n = 0;
    bit m_run, m_first, m_open, m_pend, m_brk;
    int m_arm, m_dead;
    logic [2:0] m_note;
    int e_addr, e_lane, e_valid, e_hit, e_miss, e_click, e_score, e_combo, e_maxc, e_done;

    function automatic int lane_of(input logic [7:0] c);
        for (int i = 0; i < LANES; i++) if (keys[i] == c) return i;
        return -1;
    endfunction

    task automatic score_hit();
        if (e_score < SMAX) e_score++;
        if (e_combo < SMAX) e_combo++;
        if (e_combo > e_maxc) e_maxc = e_combo;
        e_click = 1;
        e_hit = 1;
    endtask

    task automatic score_miss();
        e_combo = 0;
        e_click = 2;
        e_miss = 1;
    endtask

    task automatic model_step();
        int ln;
        ln = -1;
        n++;
        e_hit = 0;
        e_miss = 0;
        if (reset) begin
            {m_run, m_open, m_pend, m_brk} = '0;
            {e_addr, e_lane, e_valid, e_click, e_score, e_combo, e_maxc, e_done} = '0;
        end else begin
            if (scan_valid) begin
                if (scancode == 8'hF0) m_brk = 1;
                else if (scancode != 8'hE0) begin
                    if (!m_brk) ln = lane_of(scancode);
                    m_brk = 0;
                end
            end
            if (start) begin
                m_run = 1; m_first = 1; m_open = 0; m_pend = 0;
                e_addr = 0; e_valid = 0; e_score = 0; e_combo = 0; e_maxc = 0; e_done = 0;
            end else if (m_run && m_pend) begin
                if (n == m_arm) begin
                    e_lane = int'(m_note[1:0]);
                    e_valid = int'(m_note[2]);
                    e_click = 0;
                    m_open = 1;
                    m_pend = 0;
                    m_dead = n + WIN;
                end
            end else if (m_run) begin
                if (m_open) begin
                    if (ln >= 0) begin
                        if (e_valid == 1 && ln == e_lane) score_hit(); else score_miss();
                        m_open = 0;
                    end else if (n == m_dead || t) begin
                        if (e_valid == 1) score_miss();
                        m_open = 0;
                    end
                    if (!m_open && e_addr == SEQ_LEN - 1) begin
                        e_done = 1; e_valid = 0; m_run = 0;
                    end
                end
                if (m_run && !m_open && t) begin
                    if (m_first) m_first = 0; else e_addr++;
                    m_note = pat[e_addr];
                    m_pend = 1;
                    m_arm = n + 2;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        cmp_en = 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) if (cmp_en) begin
        chk("seq_addr", int'(seq_addr), e_addr);
        chk("expected_valid", int'(expected_valid), e_valid);
        if (e_valid == 1) chk("expected_lane", int'(expected_lane), e_lane);
        chk("hit", int'(hit), e_hit);
        chk("miss", int'(miss), e_miss);
        chk("click_state", int'(click_state), e_click);
        chk("score", int'(score), e_score);
        chk("combo", int'(combo), e_combo);
        chk("max_combo", int'(max_combo), e_maxc);
        chk("done", int'(done), e_done);
    end

    task automatic drive(input logic s, input logic tt, input logic v, input logic [7:0] c);
        start = s; t = tt; scan_valid = v; scancode = c;
        @(posedge clk); #1;
        start = 0; t = 0; scan_valid = 0;
    endtask

    task automatic idle(input int k);
        repeat (k) drive(0, 0, 0, 8'h00);
    endtask

    task automatic key(input logic [7:0] c);
        drive(0, 0, 1, c);
    endtask

    task automatic beat();
        drive(0, 1, 0, 8'h00);
        idle(2);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_combo"}, int'(combo), 0);
        chk({tag, "_max"}, int'(max_combo), 0);
        chk({tag, "_addr"}, int'(seq_addr), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_valid"}, int'(expected_valid), 0);
        chk({tag, "_click"}, int'(click_state), 0);
        chk({tag, "_pulse"}, int'(hit | miss), 0);
    endtask

    initial begin
        for (int i = 0; i < SEQ_LEN; i++) pat[i] = 3'b100 | 3'(i % 4);
        pat[0] = 3'b110; pat[1] = 3'b100; pat[2] = 3'b111; pat[3] = 3'b000; pat[4] = 3'b001;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        all_zero("rst");
        drive(1, 0, 0, 8'h00);
        beat();
        chk("arm_lane", int'(expected_lane), 2);
        chk("arm_valid", int'(expected_valid), 1);
        key(8'h23);
        chk("hit1", int'(hit), 1);
        chk("hit1_score", int'(score), 1);
        chk("hit1_combo", int'(combo), 1);
        chk("hit1_click", int'(click_state), 1);
        idle(3);
        beat();
        chk("lane0", int'(expected_lane), 0);
        key(8'h1b);
        chk("wrong_miss", int'(miss), 1);
        chk("wrong_combo", int'(combo), 0);
        key(8'h1c);
        chk("second_press", int'(hit | miss), 0);
        chk("second_score", int'(score), 1);
        idle(2);
        beat();
        key(8'hF0);
        key(8'h2b);
        chk("release", int'(hit | miss), 0);
        idle(13);
        chk("pre_expire", int'(miss), 0);
        idle(1);
        chk("expire_miss", int'(miss), 1);
        chk("expire_click", int'(click_state), 2);
        beat();
        idle(WIN);
        chk("rest_quiet", int'(hit | miss), 0);
        chk("rest_click", int'(click_state), 0);
        beat();
        key(8'h1c);
        chk("rest_press", int'(miss), 1);

        for (int i = 0; i < SEQ_LEN; i++) pat[i] = 3'b100 | 3'($urandom_range(0, 3));
        idle(2);
        drive(1, 0, 0, 8'h00);
        for (int b = 0; b < SEQ_LEN; b++) begin
            beat();
            key(b == 5 ? keys[(int'(pat[b][1:0]) + 1) % 4] : keys[pat[b][1:0]]);
            if (b == 7) begin
                chk("run_combo", int'(combo), 2);
                chk("run_max", int'(max_combo), 5);
                chk("run_score", int'(score), 7);
            end
            if (b == 8) chk("score_sat", int'(score), 7);
            idle(1);
        end
        chk("end_done", int'(done), 1);
        chk("end_addr", int'(seq_addr), SEQ_LEN - 1);
        chk("end_valid", int'(expected_valid), 0);
        beat();
        idle(2);
        chk("done_hold", int'(done), 1);
        chk("done_addr", int'(seq_addr), SEQ_LEN - 1);
        drive(1, 0, 0, 8'h00);
        chk("restart_done", int'(done), 0);
        chk("restart_score", int'(score), 0);
        chk("restart_max", int'(max_combo), 0);

        for (int s = 0; s < 4; s++) begin
            reset = 1;
            for (int i = 0; i < SEQ_LEN; i++) pat[i] = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            reset = 0;
            drive(1, 0, 0, 8'h00);
            for (int c = 0; c < 400; c++) begin
                int r;
                logic [7:0] code;
                r = $urandom_range(0, 7);
                code = r < 4 ? keys[r] : r == 4 ? 8'hF0 : r == 5 ? 8'hE0 : r == 6 ? 8'h55 : keys[e_lane];
                drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, code);
            end
        end

        drive(1, 0, 0, 8'h00);
        beat();
        key(8'h1c);
        reset = 1;
        @(posedge clk); #1;
        all_zero("midrst");
        reset = 0;
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
